// File: rtl/mod_split_unif.sv
// mod_split_unif: decodes an (A, B) coded pair into a data byte and a
// condition bit. A legal pair differs by +3 (cond=1) or -1 (cond=0).
// Anything else is flagged as an error and locks the input until clr_err.
// Results sit in a single output register with a valid/ready handshake
// and support one pair per cycle.
// Optional build macro: SPLIT_UNIF_ERRCNT_EN adds a saturating error counter.
// Without it, err_count is tied to zero and the counter flops are not built.

// Combinational pair decoder.
module mod_split_unif_dec (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] data,
  output logic       cond,
  output logic       err
);
  logic [7:0] diff;

  // Classify the pair by the modulo-256 distance from A to B.
  always_comb begin
    diff = b - a;
    data = a;
    cond = 1'b0;
    err  = 1'b0;
    case (diff)
      8'h03:   cond = 1'b1;
      8'hFF:   data = a + 8'd1;
      default: err  = 1'b1;
    endcase
  end
endmodule

module mod_split_unif (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_cond,
  output logic       out_err,
  input  logic       clr_err,
  output logic [7:0] err_count
);
  typedef enum logic [0:0] {RUN = 1'b0, LOCK = 1'b1} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       cond;
    logic       err;
  } res_t;

  state_t state_q, state_d;
  res_t   res_q, dec;
  logic   vld_q;
  logic   accept;

  mod_split_unif_dec u_dec (
    .a    (in_a),
    .b    (in_b),
    .data (dec.data),
    .cond (dec.cond),
    .err  (dec.err)
  );

  // The output register can take a new pair when it is empty or draining
  // this cycle. A reset cycle never completes a handshake, so ready is
  // held low while reset is high.
  assign in_ready = !reset && (state_q == RUN) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output register. A load in the same cycle as a drain keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      vld_q <= 1'b1;
      res_q <= dec;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = res_q.data;
  assign out_cond  = res_q.cond;
  assign out_err   = res_q.err;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state. An illegal accept locks the input. clr_err releases
  // the lock and is ignored in RUN. In LOCK no accept can happen, so
  // clr_err cannot race an illegal accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (accept && dec.err) state_d = LOCK;
      LOCK:    if (clr_err)           state_d = RUN;
      default: state_d = RUN;
    endcase
  end

`ifdef SPLIT_UNIF_ERRCNT_EN
  logic [7:0] cnt_q;

  // Saturating count of illegal pairs. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)                                 cnt_q <= 8'h00;
    else if (accept && dec.err && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end

  assign err_count = cnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_mod_split_unif.sv
// Randomized scoreboard bench for mod_split_unif. The stimulus side drives
// pairs. A negedge monitor pushes expected results when an accept happens
// and pops and compares them when results are handed off.
module tb_mod_split_unif;
  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready, clr_err;
  logic [7:0] in_a, in_b;
  logic       in_ready, out_valid, out_cond, out_err;
  logic [7:0] out_data, err_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       e;
  } exp_t;

  exp_t q[$];
  bit   locked = 1'b0;
  int   cnt_m  = 0;

`ifdef SPLIT_UNIF_ERRCNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  mod_split_unif dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cond  (out_cond),
    .out_err   (out_err),
    .clr_err   (clr_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode using plain integer arithmetic on the coded pair.
  function automatic exp_t ref_dec(input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int   d;
    d = (int'(b) - int'(a) + 256) % 256;
    r.d = a;
    r.c = 1'b0;
    r.e = 1'b0;
    if (d == 3) r.c = 1'b1;
    else if (d == 255) r.d = 8'((int'(a) + 1) % 256);
    else r.e = 1'b1;
    return r;
  endfunction

  // Monitor and scoreboard. Inputs are stable at negedge, so the handshakes
  // seen here are the ones the next posedge completes.
  always @(negedge clk) begin
    exp_t e;
    chk("out_valid", out_valid, q.size() != 0);
    if (out_valid && q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_cond", out_cond, q[0].c);
      chk("out_err",  out_err,  q[0].e);
    end
    chk("in_ready", in_ready, !reset && !locked && (q.size() == 0 || out_ready));
    chk("err_count", err_count, cnt_m);
    if (reset) begin
      q.delete();
      locked = 1'b0;
      cnt_m  = 0;
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        e = ref_dec(in_a, in_b);
        q.push_back(e);
        if (e.e) begin
          locked = 1'b1;
          if (CNT_ON && cnt_m < 255) cnt_m++;
        end
      end else if (clr_err) begin
        locked = 1'b0;
      end
    end
  end

  // Offer one pair and hold it until accepted. Called and returns at posedge+1.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] a;
    int         k;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_data", out_data, 8'h00);
    chk("rst_cond", out_cond, 1'b0);
    chk("rst_err",  out_err,  1'b0);
    chk("rst_cnt",  err_count, 8'h00);
    @(posedge clk); #1;

    // Basic legal pair and the latency-1 result.
    out_ready = 1'b1;
    send(8'h10, 8'h13);
    @(negedge clk);
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_data",  out_data,  8'h10);
    chk("lat_cond",  out_cond,  1'b1);
    @(posedge clk); #1;

    // Wrap-around pairs.
    send(8'hFF, 8'hFE);
    @(negedge clk);
    chk("wrap0_data", out_data, 8'h00);
    chk("wrap0_cond", out_cond, 1'b0);
    @(posedge clk); #1;
    send(8'hFE, 8'h01);
    @(negedge clk);
    chk("wrap1_data", out_data, 8'hFE);
    chk("wrap1_cond", out_cond, 1'b1);
    @(posedge clk); #1;

    // Backpressure: held result stays put and ready stays low.
    out_ready = 1'b0;
    send(8'h01, 8'h04);
    in_a = 8'h02; in_b = 8'h05; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 8'(8'h43 + i));

    // Illegal pair locks the input until clr_err.
    send(8'h20, 8'h25);
    in_a = 8'h30; in_b = 8'h33; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    pulse_clr();
    @(negedge clk);
    chk("unlock_ready", in_ready, 1'b1);
    chk("unlock_cnt", err_count, CNT_ON ? 8'h01 : 8'h00);
    @(posedge clk); #1;

    // Random streaming with random backpressure and clr_err pulses.
    for (int i = 0; i < 400; i++) begin
      a = 8'($urandom);
      k = $urandom_range(0, 15);
      in_a = a;
      in_b = (k < 7) ? 8'(a + 8'd3) : (k < 14) ? 8'(a - 8'd1) : 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_err   = ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
    pulse_clr();

    // Many illegal pairs drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      send(8'(i), 8'(i + 7));
      pulse_clr();
    end
    @(negedge clk);
    chk("sat_cnt", err_count, CNT_ON ? 8'hFF : 8'h00);
    @(posedge clk); #1;

    // Reset with a held result discards it.
    out_ready = 1'b0;
    send(8'h50, 8'h53);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b0);
    chk("post_rst_data",  out_data,  8'h00);
    chk("post_rst_cond",  out_cond,  1'b0);
    chk("post_rst_err",   out_err,   1'b0);
    chk("post_rst_cnt",   err_count, 8'h00);
    chk("post_rst_ready", in_ready,  1'b1);
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
